dbg_executor: RTL and testbench

DBG_EXECUTOR -- requirements
Module: dbg_executor

---
 rtl/dbg_pkg.sv | 26 ++
 rtl/dbg_resp_shifter.sv | 45 ++++
 rtl/dbg_executor.sv | 157 +++++++++++++++
 tb/tb_dbg_executor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared opcode, status and state definitions for the debug command executor.
package dbg_pkg;

    typedef enum logic [7:0] {
        OP_READ  = 8'h01,
        OP_WRITE = 8'h02,
        OP_PING  = 8'h03
    } dbg_op_e;

    localparam logic [7:0] STS_OK      = 8'h00;
    localparam logic [7:0] STS_BUSERR  = 8'h01;
    localparam logic [7:0] STS_TIMEOUT = 8'h02;
    localparam logic [7:0] STS_BADOP   = 8'h03;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE        = 2'd0;
    localparam state_t ST_BUS         = 2'd1;
    localparam state_t ST_RESP_STATUS = 2'd2;
    localparam state_t ST_RESP_DATA   = 2'd3;

    function automatic logic is_bus_op(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/dbg_resp_shifter.sv
// Holds a captured read word and hands it out one byte at a time, MSB first.
module dbg_resp_shifter import dbg_pkg::*; #(
    parameter int NBytes = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [NBytes*8-1:0]   word_in,
    input  logic                  shift,
    output logic [7:0]            byte_out,
    output logic                  last
);

    localparam int W    = NBytes * 8;
    localparam int CntW = $clog2(NBytes + 1);

    logic [W-1:0]    word_q, word_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (load) begin
            word_d = word_in;
            cnt_d  = CntW'(NBytes);
        end else if (shift && (cnt_q != '0)) begin
            word_d = word_q << 8;
            cnt_d  = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign byte_out = word_q[W-1 -: 8];
    assign last     = (cnt_q == CntW'(1));

endmodule

// File: rtl/dbg_executor.sv
// Executes decoded debug commands on a simple request/ack bus and streams
// a status byte (plus read data) back through a byte transmitter.
module dbg_executor import dbg_pkg::*; #(
    parameter int AdrW       = 4,
    parameter int DatW       = 4,
    parameter int BusTimeout = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [7:0]          cmd_opcode,
    input  logic [AdrW*8-1:0]   cmd_addr,
    input  logic [DatW*8-1:0]   cmd_wdata,
    output logic                bus_req,
    output logic                bus_we,
    output logic [AdrW*8-1:0]   bus_addr,
    output logic [DatW*8-1:0]   bus_wdata,
    input  logic                bus_ack,
    input  logic                bus_err,
    input  logic [DatW*8-1:0]   bus_rdata,
    output logic                tx_valid,
    output logic [7:0]          tx_data,
    input  logic                tx_ready,
    output logic                busy,
    output logic                timeout_pulse
);

    localparam int AW   = AdrW * 8;
    localparam int DW   = DatW * 8;
    localparam int CntW = $clog2(BusTimeout + 1);
    localparam logic [CntW:0] CntLim = (CntW + 1)'(BusTimeout);

    state_t          state_q, state_d;
    logic [7:0]      op_q, op_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [7:0]      status_q, status_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tp_q, tp_d;

    logic            sh_load, sh_shift, sh_last;
    logic [7:0]      sh_byte;
    logic [CntW:0]   cnt_inc;

    // One extra bit so the limit compare cannot alias when the counter is full.
    assign cnt_inc = {1'b0, cnt_q} + {{CntW{1'b0}}, 1'b1};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        tp_d     = 1'b0;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_opcode;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    cnt_d   = '0;
                    if (is_bus_op(cmd_opcode)) begin
                        state_d = ST_BUS;
                    end else begin
                        state_d  = ST_RESP_STATUS;
                        status_d = (cmd_opcode == OP_PING) ? STS_OK : STS_BADOP;
                    end
                end
            end
            ST_BUS: begin
                if (bus_err) begin
                    status_d = STS_BUSERR;
                    state_d  = ST_RESP_STATUS;
                end else if (bus_ack) begin
                    status_d = STS_OK;
                    sh_load  = (op_q == OP_READ);
                    state_d  = ST_RESP_STATUS;
                end else if (cnt_inc == CntLim) begin
                    status_d = STS_TIMEOUT;
                    tp_d     = 1'b1;
                    state_d  = ST_RESP_STATUS;
                end else begin
                    cnt_d = cnt_inc[CntW-1:0];
                end
            end
            ST_RESP_STATUS: begin
                if (tx_ready) begin
                    state_d = ((op_q == OP_READ) && (status_q == STS_OK)) ? ST_RESP_DATA : ST_IDLE;
                end
            end
            ST_RESP_DATA: begin
                if (tx_ready) begin
                    sh_shift = 1'b1;
                    if (sh_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            status_q <= '0;
            cnt_q    <= '0;
            tp_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            tp_q     <= tp_d;
        end
    end

    dbg_resp_shifter #(
        .NBytes (DatW)
    ) u_resp_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sh_load),
        .word_in  (bus_rdata),
        .shift    (sh_shift),
        .byte_out (sh_byte),
        .last     (sh_last)
    );

    always_comb begin
        tx_data = 8'h00;
        if (state_q == ST_RESP_STATUS) begin
            tx_data = status_q;
        end else if (state_q == ST_RESP_DATA) begin
            tx_data = sh_byte;
        end
    end

    assign cmd_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign bus_req       = (state_q == ST_BUS);
    assign bus_we        = bus_req && (op_q == OP_WRITE);
    assign bus_addr      = addr_q;
    assign bus_wdata     = wdata_q;
    assign tx_valid      = (state_q == ST_RESP_STATUS) || (state_q == ST_RESP_DATA);
    assign timeout_pulse = tp_q;

endmodule

// File: tb/tb_dbg_executor.sv
// Directed bench for dbg_executor: reads, writes, timeout, bad opcode, ping,
// ack/err collision, ack on the timeout cycle and reset during a response.
module tb_dbg_executor;

    localparam int AdrW       = 4;
    localparam int DatW       = 4;
    localparam int BusTimeout = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [7:0]          cmd_opcode;
    logic [AdrW*8-1:0]   cmd_addr;
    logic [DatW*8-1:0]   cmd_wdata;
    logic                bus_req;
    logic                bus_we;
    logic [AdrW*8-1:0]   bus_addr;
    logic [DatW*8-1:0]   bus_wdata;
    logic                bus_ack;
    logic                bus_err;
    logic [DatW*8-1:0]   bus_rdata;
    logic                tx_valid;
    logic [7:0]          tx_data;
    logic                tx_ready;
    logic                busy;
    logic                timeout_pulse;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] rx[$];

    always #5 clk = ~clk;

    dbg_executor #(
        .AdrW       (AdrW),
        .DatW       (DatW),
        .BusTimeout (BusTimeout)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_opcode    (cmd_opcode),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_ack       (bus_ack),
        .bus_err       (bus_err),
        .bus_rdata     (bus_rdata),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        int w;
        w = 0;
        while (!cmd_ready && w < 20) begin
            step();
            w++;
        end
        check("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_addr   = addr;
        cmd_wdata  = wdata;
        step();
        cmd_valid  = 1'b0;
        cmd_opcode = 8'hEE;
        cmd_addr   = '1;
        cmd_wdata  = '1;
    endtask

    // Bus stays pending n cycles; the response is driven in the n-th bus_req cycle.
    task automatic bus_phase(input int n, input bit ack, input bit err, input logic [31:0] rdata,
                             input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        for (int i = 1; i <= n; i++) begin
            check("bus_req_high", bus_req, 1);
            check("bus_we", bus_we, we);
            check("bus_addr", bus_addr, addr);
            check("bus_wdata", bus_wdata, wdata);
            if (i == n) begin
                bus_ack   = ack;
                bus_err   = err;
                bus_rdata = rdata;
            end
            step();
        end
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        bus_rdata = '0;
        check("bus_req_drop", bus_req, 0);
    endtask

    task automatic recv(input int n, input bit stall, output int cycles);
        logic [7:0] held_b;
        bit         held;
        held   = 1'b0;
        held_b = 8'h00;
        cycles = 0;
        rx.delete();
        while (rx.size() < n && cycles < 40) begin
            tx_ready = stall ? cycles[0] : 1'b1;
            if (held && tx_valid) check("tx_data_stable", tx_data, held_b);
            held = 1'b0;
            if (tx_valid && tx_ready) rx.push_back(tx_data);
            else if (tx_valid) begin
                held   = 1'b1;
                held_b = tx_data;
            end
            step();
            cycles++;
        end
        tx_ready = 1'b0;
        check("tx_byte_count", rx.size(), n);
    endtask

    // exp holds the expected bytes packed MSB first in its low n bytes.
    task automatic recv_and_check(input string tag, input int n, input logic [39:0] exp, input bit stall);
        int cycles;
        recv(n, stall, cycles);
        for (int i = 0; i < n; i++) begin
            if (i < rx.size()) check(tag, rx[i], exp[8*(n-1-i) +: 8]);
            else check(tag, 64'hX, exp[8*(n-1-i) +: 8]);
        end
        if (!stall) check({tag, "_cycles"}, cycles, n);
        check({tag, "_idle_ready"}, cmd_ready, 1);
        check({tag, "_idle_txv"}, tx_valid, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        int req_cnt;
        int tp_cnt;
        int tp_idx;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = 8'h00;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        bus_ack    = 1'b0;
        bus_err    = 1'b0;
        bus_rdata  = '0;
        tx_ready   = 1'b0;
        repeat (3) step();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout_pulse, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_tx_data", tx_data, 0);
        rst_n = 1'b1;
        step();

        // Bus responses while idle must not start anything.
        bus_ack = 1'b1;
        bus_err = 1'b1;
        step();
        bus_ack = 1'b0;
        bus_err = 1'b0;
        step();
        check("idle_ack_ignored_ready", cmd_ready, 1);
        check("idle_ack_ignored_txv", tx_valid, 0);

        send_cmd(8'h01, 32'h10, 32'h0);
        bus_phase(3, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h10, 32'h0);
        recv_and_check("read_bytes", 5, 40'h00DEADBEEF, 1'b0);

        send_cmd(8'h02, 32'h20, 32'h12345678);
        bus_phase(1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 32'h12345678);
        recv_and_check("write_bytes", 1, 40'h00, 1'b1);

        send_cmd(8'h01, 32'h44, 32'h0);
        req_cnt = 0;
        tp_cnt  = 0;
        tp_idx  = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus_req) req_cnt++;
            if (timeout_pulse) begin
                tp_cnt++;
                tp_idx = i;
            end
            step();
        end
        check("timeout_req_cycles", req_cnt, BusTimeout);
        check("timeout_pulse_count", tp_cnt, 1);
        check("timeout_pulse_when", tp_idx, BusTimeout);
        check("timeout_txv", tx_valid, 1);
        recv_and_check("timeout_bytes", 1, 40'h02, 1'b0);

        send_cmd(8'h7F, 32'h0, 32'h0);
        check("badop_no_req", bus_req, 0);
        check("badop_txv", tx_valid, 1);
        recv_and_check("badop_bytes", 1, 40'h03, 1'b1);

        send_cmd(8'h03, 32'h0, 32'h0);
        check("ping_no_req", bus_req, 0);
        recv_and_check("ping_bytes", 1, 40'h00, 1'b0);

        send_cmd(8'h01, 32'h30, 32'h0);
        bus_phase(2, 1'b1, 1'b1, 32'h11223344, 1'b0, 32'h30, 32'h0);
        recv_and_check("ackerr_bytes", 1, 40'h01, 1'b0);

        // Ack arriving on the very cycle the wait limit is hit beats the timeout.
        send_cmd(8'h01, 32'h50, 32'h0);
        bus_phase(BusTimeout, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 32'h50, 32'h0);
        check("edge_ack_no_timeout", timeout_pulse, 0);
        recv_and_check("edge_ack_bytes", 5, 40'h00CAFEF00D, 1'b0);

        send_cmd(8'h01, 32'h60, 32'h0);
        bus_phase(2, 1'b1, 1'b0, 32'hA5C35A3C, 1'b0, 32'h60, 32'h0);
        check("rstmid_status", tx_data, 8'h00);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("rstmid_data_txv", tx_valid, 1);
        check("rstmid_data_byte", tx_data, 8'hA5);
        step();
        check("rstmid_data_hold", tx_data, 8'hA5);
        rst_n = 1'b0;
        #1;
        check("rstmid_txv", tx_valid, 0);
        check("rstmid_ready", cmd_ready, 1);
        check("rstmid_busy", busy, 0);
        check("rstmid_tx_data", tx_data, 0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_txv", tx_valid, 0);

        send_cmd(8'h03, 32'h0, 32'h0);
        recv_and_check("post_rst_ping", 1, 40'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d of %0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
